// File: rtl/bank_responder.sv
// Bank-side responder: executes granted {we,addr,wdata} requests against a local register bank.
// Latency: 1 cycle from grant sample to resp_valid pulse; full throughput on every port.
// Backpressure: none; consumers must take each response in the cycle it is valid.
module bank_responder #(
  parameter int COUNTER_WIDTH = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int VALUE_WIDTH   = 8,
  parameter int NCONSUMERS    = 2,
  parameter int NPORTS        = 1,
  localparam int CID_WIDTH    = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
  localparam int REQ_WIDTH    = ADDR_WIDTH + VALUE_WIDTH + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NPORTS-1:0]                     grant_valid,
  input  logic [NPORTS-1:0][CID_WIDTH-1:0]      grant_id,
  input  logic [NPORTS-1:0][REQ_WIDTH-1:0]      grant_req,
  output logic [NCONSUMERS-1:0]                 resp_valid,
  output logic [NCONSUMERS-1:0]                 resp_we,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
  output logic [COUNTER_WIDTH-1:0]              value,
  output logic                                  conflict,
  output logic                                  error
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [VALUE_WIDTH-1:0] wdata;
  } req_t;

  logic [VALUE_WIDTH-1:0] mem [DEPTH];
  req_t [NPORTS-1:0]      req;
  logic [NPORTS-1:0]      exec;
  logic                   bad_now;
  logic                   conf_now;
  logic [COUNTER_WIDTH-1:0] inc;
  logic [NCONSUMERS-1:0]  rv_n;
  logic [NCONSUMERS-1:0]  rwe_n;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] rdata_n;
  logic [NCONSUMERS-1:0]  rv_q;

  assign req = grant_req;

  // A port executes only if its id is legal and no lower valid port already claims that id.
  always_comb begin
    exec    = '0;
    bad_now = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      exec[p] = grant_valid[p] && (int'(grant_id[p]) < NCONSUMERS);
      for (int q = 0; q < p; q++) begin
        if (grant_valid[q] && (grant_id[q] == grant_id[p])) exec[p] = 1'b0;
      end
      if (grant_valid[p] && !exec[p]) bad_now = 1'b1;
    end
  end

  always_comb begin
    conf_now = 1'b0;
    inc      = '0;
    rv_n     = '0;
    rwe_n    = resp_we;
    rdata_n  = resp_data;
    for (int p = 0; p < NPORTS; p++) begin
      inc = inc + {{(COUNTER_WIDTH-1){1'b0}}, exec[p]};
      for (int q = 0; q < p; q++) begin
        if (exec[p] && exec[q] && req[p].we && req[q].we && (req[p].addr == req[q].addr))
          conf_now = 1'b1;
      end
      if (exec[p]) begin
        rv_n[grant_id[p]]    = 1'b1;
        rwe_n[grant_id[p]]   = req[p].we;
        rdata_n[grant_id[p]] = req[p].we ? '0 : mem[req[p].addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      rv_q      <= '0;
      resp_we   <= '0;
      resp_data <= '0;
      value     <= '0;
      conflict  <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Descending order so the lowest-index colliding writer lands last and wins.
      for (int p = NPORTS-1; p >= 0; p--) begin
        if (exec[p] && req[p].we) mem[req[p].addr] <= req[p].wdata;
      end
      rv_q      <= rv_n;
      resp_we   <= rwe_n;
      resp_data <= rdata_n;
      value     <= value + inc;
      conflict  <= conf_now;
      error     <= error | bad_now;
    end
  end

  // A response already registered when reset arrives must not reach the consumer.
  assign resp_valid = rv_q & ~{NCONSUMERS{reset}};

endmodule

// File: tb/tb_bank_responder.sv
// Randomized and directed bench for bank_responder with a queue-free behavioural bank model.
module tb_bank_responder;

  localparam int NP = 2;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int AW = 4;
  localparam int VW = 8;
  localparam int RW = AW + VW + 1;

  logic                    clk;
  logic                    reset;
  logic [NP-1:0]           grant_valid;
  logic [NP-1:0][CW-1:0]   grant_id;
  logic [NP-1:0][RW-1:0]   grant_req;
  logic [NC-1:0]           resp_valid;
  logic [NC-1:0]           resp_we;
  logic [NC-1:0][VW-1:0]   resp_data;
  logic [7:0]              value;
  logic                    conflict;
  logic                    error;

  bank_responder #(
    .COUNTER_WIDTH(8), .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NPORTS(NP)
  ) dut (
    .clk(clk), .reset(reset), .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_req(grant_req), .resp_valid(resp_valid), .resp_we(resp_we),
    .resp_data(resp_data), .value(value), .conflict(conflict), .error(error)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int ncmp = 0;
  int nbad = 0;
  bit chk_en = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: walk the ports in priority order with a set of claimed ids and written addresses.
  logic [VW-1:0]         m_mem [16];
  logic [VW-1:0]         m_old [16];
  bit                    m_seen [NC];
  bit                    m_wr [16];
  logic [NC-1:0]         m_rv = '0;
  logic [NC-1:0]         m_rwe = '0;
  logic [NC-1:0][VW-1:0] m_rdata = '0;
  logic [7:0]            m_value = '0;
  logic                  m_conf = 0;
  logic                  m_err = 0;
  int                    m_n, m_id;
  logic                  m_we;
  logic [AW-1:0]         m_addr;
  logic [VW-1:0]         m_wd;

  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 16; a++) m_mem[a] = '0;
      m_rv = '0; m_rwe = '0; m_rdata = '0; m_value = '0; m_conf = 0; m_err = 0;
    end else begin
      m_old = m_mem;
      m_n = 0; m_rv = '0; m_conf = 0;
      for (int c = 0; c < NC; c++) m_seen[c] = 0;
      for (int a = 0; a < 16; a++) m_wr[a] = 0;
      for (int p = 0; p < NP; p++) begin
        if (grant_valid[p]) begin
          m_id = int'(grant_id[p]);
          {m_we, m_addr, m_wd} = grant_req[p];
          if (m_id >= NC || m_seen[m_id]) m_err = 1;
          else begin
            m_seen[m_id] = 1;
            m_n++;
            m_rv[m_id] = 1;
            m_rwe[m_id] = m_we;
            if (m_we) begin
              m_rdata[m_id] = '0;
              if (m_wr[m_addr]) m_conf = 1;
              else begin
                m_wr[m_addr] = 1;
                m_mem[m_addr] = m_wd;
              end
            end else m_rdata[m_id] = m_old[m_addr];
          end
        end
      end
      m_value = m_value + 8'(m_n);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("resp_valid", 64'(resp_valid), 64'(reset ? '0 : m_rv));
      cmp("resp_we", 64'(resp_we), 64'(m_rwe));
      cmp("resp_data", 64'(resp_data), 64'(m_rdata));
      cmp("value", 64'(value), 64'(m_value));
      cmp("conflict", 64'(conflict), 64'(m_conf));
      cmp("error", 64'(error), 64'(m_err));
    end
  end

  task automatic drive(input logic rst,
                       input logic v0, input logic [1:0] id0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [1:0] id1, input logic we1, input logic [3:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    reset = rst;
    grant_valid = {v1, v0};
    grant_id[0] = id0;
    grant_id[1] = id1;
    grant_req[0] = {we0, a0, d0};
    grant_req[1] = {we1, a1, d1};
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; grant_valid = '0; grant_id = '0; grant_req = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;

    // Reset state
    idle();
    cmp("rst_value", 64'(value), 64'h0);
    cmp("rst_error", 64'(error), 64'h0);
    cmp("rst_resp_valid", 64'(resp_valid), 64'h0);

    // T1: read every address from consumer 0
    for (int a = 0; a < 16; a++) begin
      drive(0, 1, 0, 0, 4'(a), 8'h00, 0, 0, 0, 0, 0);
      cmp("t1_valid", 64'(resp_valid[0]), 64'(a > 0));
      cmp("t1_value", 64'(value), 64'(a));
    end
    idle();
    cmp("t1_last_data", 64'(resp_data[0]), 64'h0);
    cmp("t1_value16", 64'(value), 64'd16);

    // T2: write then read-after-write
    do_reset();
    drive(0, 1, 1, 1, 4'd3, 8'hA5, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 4'd3, 8'h00, 0, 0, 0, 0, 0);
    cmp("t2_ack_valid", 64'(resp_valid), 64'b010);
    cmp("t2_ack_we", 64'(resp_we[1]), 64'h1);
    cmp("t2_ack_data", 64'(resp_data[1]), 64'h0);
    idle();
    cmp("t2_rd_valid", 64'(resp_valid), 64'b001);
    cmp("t2_rd_data", 64'(resp_data[0]), 64'hA5);
    cmp("t2_value", 64'(value), 64'd2);

    // T3: same-cycle write and read of one address
    do_reset();
    drive(0, 1, 0, 1, 4'd5, 8'h11, 1, 1, 0, 4'd5, 8'h00);
    drive(0, 1, 0, 0, 4'd5, 8'h00, 0, 0, 0, 0, 0);
    cmp("t3_valid", 64'(resp_valid), 64'b011);
    cmp("t3_old_data", 64'(resp_data[1]), 64'h00);
    idle();
    cmp("t3_new_data", 64'(resp_data[0]), 64'h11);
    cmp("t3_value", 64'(value), 64'd3);

    // T4: write/write collision
    do_reset();
    drive(0, 1, 0, 1, 4'd7, 8'h22, 1, 1, 1, 4'd7, 8'h33);
    drive(0, 1, 0, 0, 4'd7, 8'h00, 0, 0, 0, 0, 0);
    cmp("t4_conflict", 64'(conflict), 64'h1);
    cmp("t4_acks", 64'({resp_valid, resp_we}), 64'b011_011);
    idle();
    cmp("t4_conflict_off", 64'(conflict), 64'h0);
    cmp("t4_winner", 64'(resp_data[0]), 64'h22);

    // T5: duplicate consumer id
    do_reset();
    drive(0, 1, 1, 0, 4'd0, 8'h00, 1, 1, 1, 4'd0, 8'hFF);
    idle();
    cmp("t5_valid", 64'(resp_valid), 64'b010);
    cmp("t5_error", 64'(error), 64'h1);
    cmp("t5_value", 64'(value), 64'd1);
    drive(0, 1, 0, 0, 4'd0, 8'h00, 0, 0, 0, 0, 0);
    idle();
    cmp("t5_no_write", 64'(resp_data[0]), 64'h00);
    cmp("t5_error_held", 64'(error), 64'h1);
    do_reset();
    idle();
    cmp("t5_error_clr", 64'(error), 64'h0);

    // T6: reset squashes a pending response and clears memory
    do_reset();
    drive(0, 1, 0, 1, 4'd9, 8'h77, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 4'd9, 8'h00, 0, 0, 0, 0, 0);
    do_reset();
    cmp("t6_squash", 64'(resp_valid), 64'h0);
    idle();
    cmp("t6_value", 64'(value), 64'h0);
    drive(0, 1, 0, 0, 4'd9, 8'h00, 0, 0, 0, 0, 0);
    idle();
    cmp("t6_mem_clr", 64'(resp_data[0]), 64'h00);
    do_reset();
    for (int i = 0; i < 256; i++) drive(0, 1, 0, 0, 4'(i), 8'h00, 0, 0, 0, 0, 0);
    idle();
    cmp("t6_wrap", 64'(value), 64'h00);

    // Randomized traffic; the per-cycle compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ia, ib;
      logic [3:0] aa, ab;
      ia = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ib = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      aa = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      ab = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      drive($urandom_range(0, 99) == 0,
            1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), aa, 8'($urandom),
            1'($urandom_range(0, 1)), ib, 1'($urandom_range(0, 1)), ab, 8'($urandom));
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
